// File: rtl/count_snapshot_fifo_if.sv
// Snapshot FIFO port bundle: upstream counter taps and requests in, FIFO head and status out.
// The slave modport is the FIFO side; the master modport is the driver side.
interface count_snapshot_fifo_if #(
    parameter int EXT_W = 8,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [3:0]         cnt;
    logic               cout;
    logic               cnt_en;
    logic               capture;
    logic               rd_en;
    logic               ovf_clr;
    logic [EXT_W+3:0]   rd_data;
    logic               empty;
    logic               full;
    logic [LVL_W-1:0]   level;
    logic               overflow;
    logic               ext_carry;

    modport slave (
        input  cnt, cout, cnt_en, capture, rd_en, ovf_clr,
        output rd_data, empty, full, level, overflow, ext_carry
    );

    modport master (
        output cnt, cout, cnt_en, capture, rd_en, ovf_clr,
        input  rd_data, empty, full, level, overflow, ext_carry
    );
endinterface

// File: rtl/count_snapshot_fifo.sv
// Extends a 4-bit counter by EXT_W bits and queues {ext, nibble} snapshots on Capture rising edges.
// Latency: one cycle push-to-head; reads are show-ahead; a snapshot pushed while full is dropped and flagged.
module count_snapshot_fifo #(
    parameter int EXT_W = 8,
    parameter int DEPTH = 4
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    count_snapshot_fifo_if.slave snap_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DAT_W = EXT_W + 4;

    logic [EXT_W-1:0] ext_q, ext_d;
    logic             ext_carry_q, ext_carry_d;
    logic             cap_q;
    logic             ovf_q, ovf_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [DAT_W-1:0] mem [DEPTH];

    logic             inc;
    logic             push_req;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic             is_empty;
    logic             is_full;
    logic [DAT_W-1:0] snapshot;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LVL_W'(DEPTH));
    assign inc      = snap_if.cout & snap_if.cnt_en;
    assign push_req = snap_if.capture & ~cap_q;
    assign pop      = snap_if.rd_en & ~is_empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
    assign push_ok  = push_req & (~is_full | pop);
    assign drop     = push_req & ~push_ok;
    // Pre-increment extension: a capture coinciding with a carry stores the old value.
    assign snapshot = {ext_q, snap_if.cnt};

    always_comb begin
        ext_d       = ext_q;
        ext_carry_d = 1'b0;
        ovf_d       = ovf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;

        if (inc) begin
            ext_d       = ext_q + EXT_W'(1);
            ext_carry_d = (ext_q == {EXT_W{1'b1}});
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (snap_if.ovf_clr) begin
            ovf_d = 1'b0;
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ext_q       <= '0;
            ext_carry_q <= 1'b0;
            cap_q       <= 1'b1;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            ext_q       <= ext_d;
            ext_carry_q <= ext_carry_d;
            cap_q       <= snap_if.capture;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    // Storage is left unreset; pointers and level alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= snapshot;
        end
    end

    assign snap_if.rd_data   = is_empty ? '0 : mem[rd_ptr_q];
    assign snap_if.empty     = is_empty;
    assign snap_if.full      = is_full;
    assign snap_if.level     = level_q;
    assign snap_if.overflow  = ovf_q;
    assign snap_if.ext_carry = ext_carry_q;
endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo with EXT_W=8, DEPTH=4; expected values are hand-computed.
module tb_count_snapshot_fifo;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    count_snapshot_fifo_if #(.EXT_W(8), .DEPTH(4)) bus ();

    count_snapshot_fifo #(.EXT_W(8), .DEPTH(4)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .snap_if (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [3:0] nib);
        bus.cnt     = nib;
        bus.capture = 1'b1;
        tick();
        bus.capture = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.capture = 1'b1;
        #12;
        n_checks++;
        if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        n_checks++;
        if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        n_checks++;
        if (bus.level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
        n_checks++;
        if (bus.rd_data !== 12'h000) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 000", bus.rd_data); end
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.ext_carry !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got ovf=%b carry=%b expected 0 0", bus.overflow, bus.ext_carry);
        end
        // Capture held high across release must not produce a push.
        rst_n = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (bus.level !== 3'd0 || bus.empty !== 1'b1) begin
            n_fail++; $display("FAIL cap_held_release: got level=%0d empty=%b expected 0 1", bus.level, bus.empty);
        end
        bus.capture = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bus.cnt_en = 1'b1;
        bus.cout   = 1'b1;
        tick(); tick(); tick();
        bus.cout   = 1'b0;
        bus.cnt     = 4'h9;
        bus.capture = 1'b1;
        tick();
        n_checks++;
        if (bus.rd_data !== 12'h039) begin n_fail++; $display("FAIL basic_rd_data: got %h expected 039", bus.rd_data); end
        n_checks++;
        if (bus.level !== 3'd1 || bus.empty !== 1'b0) begin
            n_fail++; $display("FAIL basic_level: got level=%0d empty=%b expected 1 0", bus.level, bus.empty);
        end
        bus.capture = 1'b0;
        tick();
        pop_one();
        n_checks++;
        if (bus.level !== 3'd0 || bus.rd_data !== 12'h000) begin
            n_fail++; $display("FAIL basic_pop: got level=%0d data=%h expected 0 000", bus.level, bus.rd_data);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) capture(4'(i));
        n_checks++;
        if (bus.level !== 3'd4 || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_full: got level=%0d full=%b ovf=%b expected 4 1 1", bus.level, bus.full, bus.overflow);
        end
        // Drop and clear in the same cycle: the drop wins.
        bus.cnt     = 4'h6;
        bus.capture = 1'b1;
        bus.ovf_clr = 1'b1;
        tick();
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.level !== 3'd4) begin
            n_fail++; $display("FAIL ovf_drop_wins: got ovf=%b level=%0d expected 1 4", bus.overflow, bus.level);
        end
        bus.capture = 1'b0;
        tick();
        n_checks++;
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
        bus.ovf_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.rd_data !== 12'h031 + 12'(i)) begin
                n_fail++; $display("FAIL ovf_order%0d: got %h expected %h", i, bus.rd_data, 12'h031 + 12'(i));
            end
            pop_one();
        end
        n_checks++;
        if (bus.empty !== 1'b1 || bus.rd_data !== 12'h000) begin
            n_fail++; $display("FAIL ovf_fifth_absent: got empty=%b data=%h expected 1 000", bus.empty, bus.rd_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) capture(4'hA + 4'(i));
        n_checks++;
        if (bus.full !== 1'b1) begin n_fail++; $display("FAIL b2b_full: got %b expected 1", bus.full); end
        bus.cnt     = 4'hE;
        bus.capture = 1'b1;
        bus.rd_en   = 1'b1;
        tick();
        bus.capture = 1'b0;
        bus.rd_en   = 1'b0;
        n_checks++;
        if (bus.level !== 3'd4 || bus.overflow !== 1'b0 || bus.rd_data !== 12'h03B) begin
            n_fail++; $display("FAIL b2b_full_pushpop: got level=%0d ovf=%b data=%h expected 4 0 03B", bus.level, bus.overflow, bus.rd_data);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.rd_data !== 12'h03B + 12'(i)) begin
                n_fail++; $display("FAIL b2b_drain%0d: got %h expected %h", i, bus.rd_data, 12'h03B + 12'(i));
            end
            pop_one();
        end
        // Push and pop while empty: only the push takes effect.
        bus.cnt     = 4'h7;
        bus.capture = 1'b1;
        bus.rd_en   = 1'b1;
        tick();
        bus.capture = 1'b0;
        bus.rd_en   = 1'b0;
        n_checks++;
        if (bus.level !== 3'd1 || bus.rd_data !== 12'h037) begin
            n_fail++; $display("FAIL b2b_empty_pushpop: got level=%0d data=%h expected 1 037", bus.level, bus.rd_data);
        end
        tick();
        pop_one();
    endtask

    task automatic test_empty_read();
        bus.rd_en = 1'b1;
        tick(); tick();
        bus.rd_en = 1'b0;
        n_checks++;
        if (bus.level !== 3'd0 || bus.rd_data !== 12'h000 || bus.empty !== 1'b1) begin
            n_fail++; $display("FAIL empty_read: got level=%0d data=%h empty=%b expected 0 000 1", bus.level, bus.rd_data, bus.empty);
        end
        bus.cout = 1'b1;
        tick(); tick();
        // ext is now 0x05; capture on the incrementing edge stores the old value.
        bus.cnt     = 4'hF;
        bus.capture = 1'b1;
        tick();
        bus.cout    = 1'b0;
        bus.capture = 1'b0;
        n_checks++;
        if (bus.rd_data !== 12'h05F) begin n_fail++; $display("FAIL coincident_capture: got %h expected 05F", bus.rd_data); end
        tick();
        pop_one();
    endtask

    task automatic test_wrap();
        int carries;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        carries = 0;
        bus.cnt_en = 1'b1;
        bus.cout   = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (bus.ext_carry === 1'b1) carries++;
        end
        n_checks++;
        if (carries !== 0) begin n_fail++; $display("FAIL wrap_early_carry: got %0d expected 0", carries); end
        tick();
        bus.cout = 1'b0;
        n_checks++;
        if (bus.ext_carry !== 1'b1) begin n_fail++; $display("FAIL wrap_carry: got %b expected 1", bus.ext_carry); end
        tick();
        n_checks++;
        if (bus.ext_carry !== 1'b0) begin n_fail++; $display("FAIL wrap_carry_pulse: got %b expected 0", bus.ext_carry); end
        capture(4'h2);
        n_checks++;
        if (bus.rd_data !== 12'h002 || bus.level !== 3'd1) begin
            n_fail++; $display("FAIL wrap_ext_zero: got data=%h level=%0d expected 002 1", bus.rd_data, bus.level);
        end
        pop_one();
    endtask

    task automatic test_clear_mid();
        capture(4'h1);
        capture(4'h2);
        capture(4'h3);
        n_checks++;
        if (bus.level !== 3'd3) begin n_fail++; $display("FAIL clear_pre_level: got %0d expected 3", bus.level); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.level !== 3'd0 || bus.empty !== 1'b1 || bus.rd_data !== 12'h000) begin
            n_fail++; $display("FAIL clear_async: got level=%0d empty=%b data=%h expected 0 1 000", bus.level, bus.empty, bus.rd_data);
        end
        bus.rd_en   = 1'b1;
        bus.capture = 1'b1;
        tick();
        n_checks++;
        if (bus.level !== 3'd0 || bus.full !== 1'b0) begin
            n_fail++; $display("FAIL clear_inputs_ignored: got level=%0d full=%b expected 0 0", bus.level, bus.full);
        end
        bus.rd_en   = 1'b0;
        bus.capture = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.cnt     = 4'h0;
        bus.cout    = 1'b0;
        bus.cnt_en  = 1'b0;
        bus.capture = 1'b0;
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_empty_read();
        test_wrap();
        test_clear_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/count_snapshot_fifo.md
COUNT_SNAPSHOT_FIFO -- requirements
Module: count_snapshot_fifo

Interface
REQ-001 Parameter EXT_W, default 8: width of extension count (carry pulses from the upstream 4-bit counter).
REQ-002 Parameter DEPTH, default 4: snapshot FIFO entries; power of two, minimum 2.
REQ-003 Clock  in  1  single clock; all state updates on rising edge.
REQ-004 Clear  in  1  reset, asynchronous, active-low.
REQ-005 Cnt_in  in  4  upstream counter value (counter D_out).
REQ-006 Cout_in  in  1  upstream counter carry (counter Cout).
REQ-007 Cnt_en  in  1  upstream count enable (En_P AND En_T of the counter).
REQ-008 Capture  in  1  snapshot request; rising-edge sensitive.
REQ-009 Rd_en  in  1  pop request for FIFO head.
REQ-010 Ovf_clr  in  1  clears Overflow.
REQ-011 Rd_data  out  EXT_W+4  FIFO head, {ext_count, low nibble}; show-ahead.
REQ-012 Empty  out  1  FIFO holds 0 entries.
REQ-013 Full  out  1  FIFO holds DEPTH entries.
REQ-014 Level  out  log2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-015 Overflow  out  1  sticky: a snapshot was dropped.
REQ-016 Ext_carry  out  1  one-cycle pulse: ext_count wrapped.

Function
REQ-017 Internal ext_count (EXT_W bits) SHALL increment by 1 on each edge where Cout_in=1 and Cnt_en=1; otherwise hold.
REQ-018 ext_count SHALL wrap all-ones -> 0 with no saturation; on the wrapping edge Ext_carry SHALL be 1 for exactly the following cycle.
REQ-019 Capture edge detector: register cap_q samples Capture each edge; push request = Capture AND NOT cap_q.
REQ-020 Snapshot value SHALL be {ext_count pre-increment, Cnt_in} as sampled on the push edge; capture coincident with increment stores old ext_count with Cnt_in (e.g. {0x05,0xF}, not {0x06,0xF}).
REQ-021 Push with Level<DEPTH: write snapshot at tail, Level+1, one-cycle latency (visible on Rd_data next cycle if FIFO was empty).
REQ-022 Push with Level=DEPTH and no valid pop: snapshot dropped, FIFO contents unchanged, Overflow set next cycle.
REQ-023 Pop: Rd_en=1 and Empty=0 removes head, Level-1; Rd_en while Empty SHALL be ignored (no underflow, no state change).
REQ-024 Simultaneous push and pop, FIFO nonempty (including Full): both SHALL occur, Level unchanged, no overflow.
REQ-025 Simultaneous push and pop, FIFO empty: pop ignored, push occurs, Level becomes 1.
REQ-026 Rd_data SHALL combinationally present head entry when Empty=0, and all zeros when Empty=1.
REQ-027 Empty = (Level==0), Full = (Level==DEPTH), both derived from registered Level, no extra latency.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; ordering strictly first-in first-out.
REQ-029 Ovf_clr=1 clears Overflow next edge; a drop in the same cycle SHALL win (Overflow stays 1).

Reset
REQ-030 Clear=0 SHALL immediately, independent of Clock, force ext_count=0, Level=0, pointers=0, Overflow=0, Ext_carry=0, cap_q=1.
REQ-031 While Clear=0 outputs SHALL read Empty=1, Full=0, Level=0, Rd_data=0; all inputs ignored.
REQ-032 cap_q reset to 1 so Capture held high across reset release produces no push; first push needs a 0->1 transition.
REQ-033 Clear asserted mid-operation SHALL discard all stored snapshots; FIFO memory contents need not be cleared.

Verification
REQ-034 Reset, Cnt_en=1, Cout_in pulsed 3 times, Capture edge with Cnt_in=0x9 -> next cycle Rd_data=0x039, Level=1, Empty=0.
REQ-035 Five Capture edges, no reads, DEPTH=4 -> Level=4, Full=1, Overflow=1; pops return first four snapshots in order; fifth absent.
REQ-036 Full FIFO, Capture edge and Rd_en same cycle -> Level stays 4, Overflow stays 0, oldest removed, new entry at tail.
REQ-037 Drive 256 Cout_in&Cnt_en pulses (EXT_W=8) -> ext_count returns 0x00, Ext_carry high exactly one cycle after 256th pulse.
REQ-038 Rd_en with Empty=1 -> Level 0, Rd_data 0x000, no state change; Capture coincident with increment at ext 0x05, Cnt_in 0xF -> stored 0x05F.
REQ-039 Capture held 1 through Clear release -> no push; Clear pulsed low mid-operation with Level=3 -> Level 0, Empty 1 immediately, without a clock edge.
